// File: rtl/s_upsample_if.sv
// Sample-stream bundle between the low-rate source and the interpolator.
// The slave side is the interpolator: it consumes Input and drives Strobe and Output.
interface s_upsample_if;
    logic [23:0] Input;
    logic        Strobe;
    logic [23:0] Output;

    modport master (output Input, input Strobe, input Output);
    modport slave  (input Input, output Strobe, output Output);
endinterface

// File: rtl/s_upsample.sv
// Linear interpolator: one 24-bit sample per 2^N clocks -> one ramp point per clock; Output lags Acc by 1 clock.
// No backpressure: Strobe pulses the cycle Input is latched. Define S_UPSAMPLE_ROUND_EN for round-half-up output.
module s_upsample #(
    parameter int N = 24
) (
    input  logic         Clk,
    input  logic         nReset,
    s_upsample_if.slave  bus
);

    logic        [N-1:0]  r_count;
    logic signed [23:0]   r_last;
    logic signed [24:0]   r_d;
    logic signed [N+24:0] r_acc;
    logic                 r_strobe;
    logic        [23:0]   r_out;

    logic                 w_load;
    logic signed [24:0]   w_val;
    logic        [23:0]   w_sat;

    assign w_load = (r_count == '0);

`ifdef S_UPSAMPLE_ROUND_EN
    // Keep one fraction bit, add one, drop it: floor + Acc[N-1].
    logic signed [25:0] w_half;
    assign w_half = 26'(r_acc >>> (N - 1));
    assign w_val  = 25'((w_half + 26'sd1) >>> 1);
`else
    assign w_val  = 25'(r_acc >>> N);
`endif

    always_comb begin
        w_sat = w_val[23:0];
        if (w_val[24] != w_val[23]) begin
            w_sat = w_val[24] ? 24'h800000 : 24'h7FFFFF;
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_count  <= '0;
            r_last   <= '0;
            r_d      <= '0;
            r_acc    <= '0;
            r_strobe <= 1'b0;
            r_out    <= '0;
        end else begin
            r_count  <= r_count + N'(1);
            r_strobe <= w_load;
            r_out    <= w_sat;
            if (w_load) begin
                // Restart from the old endpoint; the 25-bit slope covers full-scale steps.
                r_last <= bus.Input;
                r_d    <= {bus.Input[23], bus.Input} - {r_last[23], r_last};
                r_acc  <= {r_last[23], r_last, {N{1'b0}}};
            end else begin
                r_acc  <= r_acc + {{N{r_d[24]}}, r_d};
            end
        end
    end

    assign bus.Strobe = r_strobe;
    assign bus.Output = r_out;

endmodule

// File: tb/tb_s_upsample.sv
// Randomized bench for s_upsample (N=4) against an arithmetic ramp model.
module tb_s_upsample;
    localparam int N = 4;
    localparam int P = 1 << N;

    logic Clk    = 1'b0;
    logic nReset = 1'b0;

    s_upsample_if bus ();

    s_upsample #(.N(N)) dut (
        .Clk    (Clk),
        .nReset (nReset),
        .bus    (bus)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    int t     = 0;
    int S[$];

    function automatic int samp(int k);
        if (k < 0 || k >= S.size()) return 0;
        return S[k];
    endfunction

    // Output after edge tt reflects the ramp point reached at edge tt-1.
    function automatic int exp_out(int tt);
        longint a, b, v, r;
        int p, c;
        if (tt == 0) return 0;
        p = (tt - 1) / P;
        c = (tt - 1) % P;
        a = samp(p - 1);
        b = samp(p);
        v = a * P + c * (b - a);
`ifdef S_UPSAMPLE_ROUND_EN
        r = (v + P / 2) >>> N;
`else
        r = v >>> N;
`endif
        if (r > 8388607)  r = 8388607;
        if (r < -8388608) r = -8388608;
        return int'(r);
    endfunction

    task automatic check(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s t=%0d got=%0d want=%0d", tag, t, obs, expv);
        end
    endtask

    function automatic int rnd_sample();
        logic [23:0] w;
        w = 24'($urandom);
        if ($urandom_range(0, 1) == 0) w = 24'($signed(w[11:0]));
        return int'($signed(w));
    endfunction

    task automatic run(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge Clk);
            #1;
            check("strobe", int'(bus.Strobe), (t % P == 0) ? 1 : 0);
            check("out", int'($signed(bus.Output)), exp_out(t));
            if ((t + 1) % P == 0) bus.Input = 24'(samp((t + 1) / P));
            else                  bus.Input = 24'($urandom);
            t++;
        end
    endtask

    initial begin
        bus.Input = 24'h000000;
        #22;
        check("rst_out", int'(bus.Output), 0);
        check("rst_strobe", int'(bus.Strobe), 0);

        S = {0, 0, 0, 0, 256, 0, 7, 0, -8388608, 8388607, -8388608, 8388607, 0};
        for (int k = 0; k < 16; k++) S.push_back(rnd_sample());
        bus.Input = 24'(S[0]);
        @(negedge Clk);
        nReset = 1'b1;
        t = 0;
        run(S.size() * P + 2);

        // Second segment: assert reset while Count==7 mid-ramp.
        nReset = 1'b0;
        #3;
        S = {1000, -2000, 50000};
        bus.Input = 24'(S[0]);
        @(negedge Clk);
        nReset = 1'b1;
        t = 0;
        run(2 * P + 7);
        check("pre_rst_out_nonzero", (bus.Output != 24'h0) ? 1 : 0, 1);
        #2;
        nReset = 1'b0;
        #1;
        check("midrst_out", int'(bus.Output), 0);
        check("midrst_strobe", int'(bus.Strobe), 0);

        S = {-300, 4096, 12345};
        for (int k = 0; k < 4; k++) S.push_back(rnd_sample());
        bus.Input = 24'(S[0]);
        @(negedge Clk);
        nReset = 1'b1;
        t = 0;
        run(S.size() * P + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
